slot_game_ctrl: RTL



---
 rtl/slot_pkg.sv | 25 ++
 rtl/slot_game_ctrl_win_eval.sv | 38 +++
 rtl/slot_game_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared constants and state encoding for the slot player-side controller.
// The core's timing constants set the default press and settle periods.
package slot_pkg;

  localparam int unsigned SYM_W = 3;
  localparam logic [SYM_W-1:0] DEF_JACKPOT_SYM = 3'd7;

  localparam logic [31:0] DEBOUNCE_CYCLES = 32'h004C4B40;
  localparam logic [31:0] REEL_STOP_CYCLES = 32'h11E1A300;

  // Press twice the debounce period; settle a fixed margin past the last reel stop.
  localparam logic [31:0] DEF_PRESS_CYCLES = DEBOUNCE_CYCLES + DEBOUNCE_CYCLES;
  localparam logic [31:0] DEF_SETTLE_CYCLES = REEL_STOP_CYCLES + 32'h011E5D00;
  localparam logic [31:0] DEF_AUTO_STOP_CYCLES = 32'h1DCD6500;

  typedef enum logic [2:0] {
    StIdle,
    StStartPress,
    StSpinning,
    StStopPress,
    StSettle,
    StEval
  } state_e;

endpackage

// File: rtl/slot_game_ctrl_win_eval.sv
// Combinational payout select from the three sampled reel symbols.
module slot_win_eval
  import slot_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned PAY_PAIR = 2,
  parameter int unsigned PAY_TRIPLE = 8,
  parameter int unsigned PAY_JACKPOT = 32,
  parameter logic [SYM_W-1:0] JACKPOT_SYM = DEF_JACKPOT_SYM
) (
  input  logic [SYM_W-1:0]    i_sym0,
  input  logic [SYM_W-1:0]    i_sym1,
  input  logic [SYM_W-1:0]    i_sym2,
  output logic [CREDIT_W-1:0] o_payout
);

  logic w_eq01;
  logic w_eq12;
  logic w_eq02;

  assign w_eq01 = (i_sym0 == i_sym1);
  assign w_eq12 = (i_sym1 == i_sym2);
  assign w_eq02 = (i_sym0 == i_sym2);

  always_comb begin
    o_payout = '0;
    if (w_eq01 && w_eq12) begin
      if (i_sym0 == JACKPOT_SYM) begin
        o_payout = CREDIT_W'(PAY_JACKPOT);
      end else begin
        o_payout = CREDIT_W'(PAY_TRIPLE);
      end
    end else if (w_eq01 || w_eq12 || w_eq02) begin
      o_payout = CREDIT_W'(PAY_PAIR);
    end
  end

endmodule

// File: rtl/slot_game_ctrl.sv
// Player-side slot controller: credit balance, start/stop press sequencing toward
// the slot core, settle wait, then win evaluation and payout.
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned       CREDIT_W         = 8,
  parameter int unsigned       CREDIT_INIT      = 10,
  parameter int unsigned       BET              = 1,
  parameter logic [31:0]       PRESS_CYCLES     = DEF_PRESS_CYCLES,
  parameter logic [31:0]       AUTO_STOP_CYCLES = DEF_AUTO_STOP_CYCLES,
  parameter logic [31:0]       SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter int unsigned       PAY_PAIR         = 2,
  parameter int unsigned       PAY_TRIPLE       = 8,
  parameter int unsigned       PAY_JACKPOT      = 32,
  parameter logic [SYM_W-1:0]  JACKPOT_SYM      = DEF_JACKPOT_SYM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_coin,
  input  logic                i_play_req,
  input  logic                i_stop_req,
  input  logic [3:0]          i_slot_in0,
  input  logic [3:0]          i_slot_in1,
  input  logic [3:0]          i_slot_in2,
  output logic                o_start_n,
  output logic                o_stop_n,
  output logic [CREDIT_W-1:0] o_credits,
  output logic [CREDIT_W-1:0] o_win_amount,
  output logic                o_win_valid,
  output logic                o_busy,
  output logic                o_no_credit
);

  localparam logic [CREDIT_W-1:0] BetC = CREDIT_W'(BET);
  localparam logic [CREDIT_W-1:0] InitC = CREDIT_W'(CREDIT_INIT);

  state_e              r_state;
  state_e              w_state_next;
  logic [31:0]         r_cnt;
  logic [CREDIT_W-1:0] r_credits;
  logic [CREDIT_W-1:0] w_credits_next;
  logic [CREDIT_W:0]   w_credit_sum;
  logic [CREDIT_W-1:0] r_win_amount;
  logic [CREDIT_W-1:0] w_win_amount_next;
  logic [CREDIT_W-1:0] w_payout;
  logic                r_start_n;
  logic                w_start_n_next;
  logic                r_stop_n;
  logic                w_stop_n_next;
  logic                r_win_valid;
  logic                w_win_valid_next;
  logic                r_busy;
  logic                r_no_credit;
  logic                w_unused_msb;

  // Bit 3 of each reel symbol carries no meaning for the win rule.
  assign w_unused_msb = ^{i_slot_in0[3], i_slot_in1[3], i_slot_in2[3]};

  slot_win_eval #(
    .CREDIT_W   (CREDIT_W),
    .PAY_PAIR   (PAY_PAIR),
    .PAY_TRIPLE (PAY_TRIPLE),
    .PAY_JACKPOT(PAY_JACKPOT),
    .JACKPOT_SYM(JACKPOT_SYM)
  ) u_win_eval (
    .i_sym0  (i_slot_in0[SYM_W-1:0]),
    .i_sym1  (i_slot_in1[SYM_W-1:0]),
    .i_sym2  (i_slot_in2[SYM_W-1:0]),
    .o_payout(w_payout)
  );

  always_comb begin
    w_state_next      = r_state;
    w_start_n_next    = r_start_n;
    w_stop_n_next     = r_stop_n;
    w_win_valid_next  = 1'b0;
    w_win_amount_next = r_win_amount;
    w_credit_sum      = {1'b0, r_credits} + {{CREDIT_W{1'b0}}, i_coin};
    unique case (r_state)
      StIdle: begin
        if (i_play_req && (r_credits >= BetC)) begin
          w_credit_sum   = w_credit_sum - {1'b0, BetC};
          w_start_n_next = 1'b0;
          w_state_next   = StStartPress;
        end
      end
      StStartPress: begin
        if (r_cnt == PRESS_CYCLES - 32'd1) begin
          w_start_n_next = 1'b1;
          w_state_next   = StSpinning;
        end
      end
      StSpinning: begin
        if (i_stop_req || (r_cnt == AUTO_STOP_CYCLES - 32'd1)) begin
          w_stop_n_next = 1'b0;
          w_state_next  = StStopPress;
        end
      end
      StStopPress: begin
        if (r_cnt == PRESS_CYCLES - 32'd1) begin
          w_stop_n_next = 1'b1;
          w_state_next  = StSettle;
        end
      end
      StSettle: begin
        if (r_cnt == SETTLE_CYCLES - 32'd1) begin
          w_state_next = StEval;
        end
      end
      StEval: begin
        w_credit_sum      = w_credit_sum + {1'b0, w_payout};
        w_win_amount_next = w_payout;
        w_win_valid_next  = 1'b1;
        w_state_next      = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // Saturate instead of wrapping when the sum overflows the balance width.
    w_credits_next = w_credit_sum[CREDIT_W] ? '1 : w_credit_sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_credits    <= InitC;
      r_start_n    <= 1'b1;
      r_stop_n     <= 1'b1;
      r_win_amount <= '0;
      r_win_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_no_credit  <= (InitC < BetC);
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= (w_state_next != r_state) ? 32'd0 : r_cnt + 32'd1;
      r_credits    <= w_credits_next;
      r_start_n    <= w_start_n_next;
      r_stop_n     <= w_stop_n_next;
      r_win_amount <= w_win_amount_next;
      r_win_valid  <= w_win_valid_next;
      r_busy       <= (w_state_next != StIdle);
      r_no_credit  <= (w_credits_next < BetC);
    end
  end

  assign o_start_n    = r_start_n;
  assign o_stop_n     = r_stop_n;
  assign o_credits    = r_credits;
  assign o_win_amount = r_win_amount;
  assign o_win_valid  = r_win_valid;
  assign o_busy       = r_busy;
  assign o_no_credit  = r_no_credit;

endmodule
